// File: rtl/qam_demapper.sv
// ---------------------------------------------------------------------------
// qam_demapper
//   Receive-side 16-QAM hard demapper with a small symbol FIFO.  Each signed
//   3-bit I/Q sample is sliced to a 2-bit Gray code per component, the
//   {I_code, Q_code} symbol is buffered, and every symbol is released to the
//   downstream decoder as two 2-bit pairs (I half first, then Q half) over a
//   valid/ready handshake.
//
// Configuration:
//   QAM_DEMAP_ERASURE_EN  when defined, adds the pair_erase output and stores
//                         a per-component decision-boundary flag in the FIFO.
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   sym_valid   in   I/Q sample valid this cycle (no backpressure)
//   I, Q        in   signed 3-bit samples, nominal -3,-1,+1,+3
//   pair_out    out  2-bit code-word pair (I half, then Q half)
//   pair_valid  out  pair_out valid (FIFO not empty)
//   pair_ready  in   decoder accepts the pair this cycle
//   overflow    out  sticky: a symbol was dropped on a full FIFO
//   pair_erase  out  (optional) current half came from a boundary sample
//   level       out  FIFO occupancy in symbols
// ---------------------------------------------------------------------------
module qam_demapper #(
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     sym_valid,
  input  logic signed [2:0]        I,
  input  logic signed [2:0]        Q,
  output logic [1:0]               pair_out,
  output logic                     pair_valid,
  input  logic                     pair_ready,
  output logic                     overflow,
`ifdef QAM_DEMAP_ERASURE_EN
  output logic                     pair_erase,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef QAM_DEMAP_ERASURE_EN
  localparam int EW = 6;   // {I_erase, Q_erase, I_code, Q_code}
`else
  localparam int EW = 4;   // {I_code, Q_code}
`endif

  // Hard decision slicer: thresholds at -2, 0, +2 of the two's-complement value.
  function automatic logic [1:0] slice_code(input logic [2:0] v);
    logic [1:0] c;
    case (v)
      3'b011, 3'b010: c = 2'b10;   // +3, +2
      3'b001, 3'b000: c = 2'b11;   // +1,  0
      3'b111, 3'b110: c = 2'b01;   // -1, -2
      3'b101, 3'b100: c = 2'b00;   // -3, -4
      default:        c = 2'b00;
    endcase
    return c;
  endfunction

  // A sample sitting exactly on a decision threshold (0, +2, -2).
  function automatic logic is_boundary(input logic [2:0] v);
    return (v == 3'b000) || (v == 3'b010) || (v == 3'b110);
  endfunction

  logic [EW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          phase_r;
  logic          overflow_r;

  logic [EW-1:0] sym_word_s;
  logic [EW-1:0] head_s;
  logic          full_s;
  logic          hs_s;
  logic          pop_s;
  logic          wr_en_s;
  logic          drop_s;

`ifdef QAM_DEMAP_ERASURE_EN
  assign sym_word_s = {is_boundary(I), is_boundary(Q), slice_code(I), slice_code(Q)};
`else
  assign sym_word_s = {slice_code(I), slice_code(Q)};
`endif

  assign head_s     = mem_r[rd_ptr_r];
  assign full_s     = (level_r == LW'(DEPTH));
  assign pair_valid = (level_r != LW'(0));
  assign hs_s       = pair_valid & pair_ready;
  // An entry leaves only once its Q half has been accepted.
  assign pop_s      = hs_s & phase_r;
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign wr_en_s    = sym_valid & (~full_s | pop_s);
  assign drop_s     = sym_valid & full_s & ~pop_s;

  // Gated with pair_valid so outputs read zero while the FIFO is empty.
  assign pair_out = pair_valid ? (phase_r ? head_s[1:0] : head_s[3:2]) : 2'b00;
`ifdef QAM_DEMAP_ERASURE_EN
  assign pair_erase = pair_valid ? (phase_r ? head_s[4] : head_s[5]) : 1'b0;
`endif

  assign level    = level_r;
  assign overflow = overflow_r;

  // Symbol storage; contents are only observed through a valid head.
  always_ff @(posedge sys_clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= sym_word_s;
    end
  end

  // Pointers, occupancy, half-select phase and sticky overflow.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= AW'(0);
      rd_ptr_r   <= AW'(0);
      level_r    <= LW'(0);
      phase_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is natural rollover.
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (hs_s) begin
        phase_r <= ~phase_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case ({wr_en_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: tb/tb_qam_demapper.sv
// ---------------------------------------------------------------------------
// tb_qam_demapper
//   Directed and randomized stimulus for qam_demapper (DEPTH=4).  The
//   reference model is a queue of outstanding pairs: each accepted symbol
//   appends its I pair and Q pair, each handshake removes the front pair.
//   Occupancy is the number of symbols with at least one pair still queued.
// ---------------------------------------------------------------------------
module tb_qam_demapper;

  localparam int DEPTH = 4;

  logic              sys_clk = 1'b0;
  logic              reset;
  logic              sym_valid;
  logic signed [2:0] I;
  logic signed [2:0] Q;
  logic [1:0]        pair_out;
  logic              pair_valid;
  logic              pair_ready;
  logic              overflow;
  logic [2:0]        level;
`ifdef QAM_DEMAP_ERASURE_EN
  logic              pair_erase;
`endif

  qam_demapper #(.DEPTH(DEPTH)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .I          (I),
    .Q          (Q),
    .pair_out   (pair_out),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .overflow   (overflow),
`ifdef QAM_DEMAP_ERASURE_EN
    .pair_erase (pair_erase),
`endif
    .level      (level)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: each entry is {erase, code[1:0]} for one pair still to be delivered.
  logic [2:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  function automatic logic [1:0] ref_code(input int x);
    if (x >= 2)       return 2'b10;
    else if (x >= 0)  return 2'b11;
    else if (x >= -2) return 2'b01;
    else              return 2'b00;
  endfunction

  function automatic logic ref_erase(input int x);
    return (x == 0) || (x == 2) || (x == -2);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    chk("pair_valid", 8'(pair_valid), 8'(sz > 0));
    chk("pair_out", 8'(pair_out), (sz > 0) ? 8'(exp_q[0][1:0]) : 8'h00);
`ifdef QAM_DEMAP_ERASURE_EN
    chk("pair_erase", 8'(pair_erase), (sz > 0) ? 8'(exp_q[0][2]) : 8'h00);
`endif
    chk("level", 8'(level), 8'((sz + 1) / 2));
    chk("overflow", 8'(overflow), 8'(exp_ovf));
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model.
  task automatic cycle(input logic sv, input logic signed [2:0] iv,
                       input logic signed [2:0] qv, input logic rdy);
    int  sz, xi, xq;
    bit  hs, pop_sym, accept;
    check_outputs();
    sym_valid  = sv;
    I          = iv;
    Q          = qv;
    pair_ready = rdy;
    sz      = exp_q.size();
    hs      = rdy && (sz > 0);
    pop_sym = hs && (sz % 2 == 1);  // odd count: the Q half is at the front
    accept  = sv && (((sz + 1) / 2 < DEPTH) || pop_sym);
    if (sv && !accept) exp_ovf = 1'b1;
    if (hs) void'(exp_q.pop_front());
    if (accept) begin
      xi = iv;
      xq = qv;
      exp_q.push_back({ref_erase(xi), ref_code(xi)});
      exp_q.push_back({ref_erase(xq), ref_code(xq)});
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_outputs();
    @(posedge sys_clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    sym_valid  = 1'b0;
    I          = 3'sd0;
    Q          = 3'sd0;
    pair_ready = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    // Reset state
    check_outputs();
    reset = 1'b1;

    // I=+3, Q=-1 with ready high: 10 then 01 on consecutive cycles
    cycle(1'b1, 3'sd3, -3'sd1, 1'b1);
    chk("first_i_half", 8'(pair_out), 8'h2);
    cycle(1'b0, 3'sd0, 3'sd0, 1'b1);
    chk("first_q_half", 8'(pair_out), 8'h1);
    cycle(1'b0, 3'sd0, 3'sd0, 1'b1);
    cycle(1'b0, 3'sd0, 3'sd0, 1'b1);

    // Sweep I and Q across -4..3
    for (int v = -4; v <= 3; v++) begin
      cycle(1'b1, 3'(v), 3'(3 - v - 4), 1'b1);
      cycle(1'b0, 3'sd0, 3'sd0, 1'b1);
      cycle(1'b0, 3'sd0, 3'sd0, 1'b1);
    end

    // Five pushes while stalled: fifth dropped, overflow sticks
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
    end
    chk("full_level", 8'(level), 8'h4);
    chk("overflow_set", 8'(overflow), 8'h1);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 3'sd0, 3'sd0, 1'b1);
    end

    // Full FIFO, Q half handshaked while a new symbol arrives: accepted
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
    end
    cycle(1'b0, 3'sd0, 3'sd0, 1'b1);          // I half out, phase now 1
    cycle(1'b1, -3'sd3, 3'sd1, 1'b1);         // pop and write together
    chk("full_pop_level", 8'(level), 8'h4);
    chk("full_pop_ovf", 8'(overflow), 8'h0);
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, 3'sd0, 3'sd0, 1'b1);
    end

    // Reset after the I half is taken, Q half pending
    cycle(1'b1, 3'sd1, -3'sd4, 1'b0);
    cycle(1'b0, 3'sd0, 3'sd0, 1'b1);
    do_reset();
    cycle(1'b1, -3'sd2, 3'sd2, 1'b1);
    chk("post_reset_i", 8'(pair_out), 8'h1);
    cycle(1'b0, 3'sd0, 3'sd0, 1'b1);

    // Boundary sample on I, clean sample on Q
    cycle(1'b1, 3'sd0, 3'sd3, 1'b1);
    cycle(1'b0, 3'sd0, 3'sd0, 1'b1);
    cycle(1'b0, 3'sd0, 3'sd0, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 3'sd0, 3'sd0, 1'b1);
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
